matmul_engine: RTL and testbench

- Parametrised hardware matrix-multiply engine: C[M][N2] = A[M][N] x B[N][N2], signed WIDTH-bit elements.
- Attaches to the data-memory port next to the RISC-V core. Reads A and B from byte-addressed, word-aligned, big-endian data memory and writes C back.
- Reports done, cycle count and MAC count, so CPU and engine runs compare directly.

---
 rtl/matmul_engine.sv | 152 +++++++++++++++
 tb/tb_matmul_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// Sequential matrix-multiply engine: C = A x B over a word-wide, big-endian data-memory port.
// One MAC per three cycles (read A, read B, accumulate), then one write per C element.
module matmul_engine #(
  parameter int M      = 2,
  parameter int N      = 4,
  parameter int N2     = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16,
  parameter int A_BASE = 0,
  parameter int B_BASE = M*N*4,
  parameter int C_BASE = M*N*4 + N*N2*4,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_wr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [CNT_W-1:0]  clock_count,
  output logic [CNT_W-1:0]  mac_count
);

  localparam int IW    = (M  > 1) ? $clog2(M)  : 1;
  localparam int JW    = (N2 > 1) ? $clog2(N2) : 1;
  localparam int KW    = (N  > 1) ? $clog2(N)  : 1;
  localparam int ACC_W = 2*WIDTH + $clog2(N);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            i_q, i_d;
  logic [JW-1:0]            j_q, j_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]         a_q, a_d;
  logic [CNT_W-1:0]         cyc_q, cyc_d;
  logic [CNT_W-1:0]         mac_q, mac_d;
  logic signed [2*WIDTH-1:0] prod;
  logic                     last_k, last_j, last_i;

  assign prod   = $signed(a_q) * $signed(mem_rdata);
  assign last_k = (k_q == KW'(N-1));
  assign last_j = (j_q == JW'(N2-1));
  assign last_i = (i_q == IW'(M-1));

  assign busy        = (state_q != IDLE);
  assign clock_count = cyc_q;
  assign mac_count   = mac_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_d       = a_q;
    cyc_d     = cyc_q;
    mac_d     = mac_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;

    // Counters saturate rather than wrap so a long run never reads as a short one.
    if (state_q != IDLE && cyc_q != '1) cyc_d = cyc_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_A;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          cyc_d   = '0;
          mac_d   = '0;
        end
      end
      RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = ADDR_W'(A_BASE + 4*(int'(i_q)*N + int'(k_q)));
        state_d  = RD_B;
      end
      RD_B: begin
        mem_rd   = 1'b1;
        mem_addr = ADDR_W'(B_BASE + 4*(int'(k_q)*N2 + int'(j_q)));
        a_d      = mem_rdata;
        state_d  = MAC;
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (mac_q != '1) mac_d = mac_q + 1'b1;
        if (last_k) begin
          state_d = WR;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RD_A;
        end
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_addr  = ADDR_W'(C_BASE + 4*(int'(i_q)*N2 + int'(j_q)));
        mem_wdata = acc_q[WIDTH-1:0];
        acc_d     = '0;
        k_d       = '0;
        if (!last_j) begin
          j_d = j_q + 1'b1;
        end else if (!last_i) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = '0;
        end
        state_d = (last_i && last_j) ? DONE : RD_A;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      cyc_q   <= '0;
      mac_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      cyc_q   <= cyc_d;
      mac_q   <= mac_d;
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench: the stimulus side computes C with plain integer arithmetic and queues the
// expected writes; a negedge monitor pops and compares every memory write and end-of-run count.
module tb_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1;
  logic        busy0, done0, rd0, wr0, busy1, done1, rd1, wr1;
  logic [15:0] addr0, addr1, cc0, mc0, cc1, mc1;
  logic [31:0] rdata0, wdata0, rdata1, wdata1;

  matmul_engine u0 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start0), .busy(busy0), .done(done0),
    .mem_addr(addr0), .mem_rd(rd0), .mem_rdata(rdata0), .mem_wr(wr0), .mem_wdata(wdata0),
    .clock_count(cc0), .mac_count(mc0)
  );

  matmul_engine #(.M(3), .N(1), .N2(3)) u1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_addr(addr1), .mem_rd(rd1), .mem_rdata(rdata1), .mem_wr(wr1), .mem_wdata(wdata1),
    .clock_count(cc1), .mac_count(mc1)
  );

  // Byte-wide big-endian memories holding A and B; read data appears the cycle after mem_rd.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always @(posedge clk) begin
    if (rd0) rdata0 <= {mem0[addr0[7:0]], mem0[addr0[7:0]+8'd1], mem0[addr0[7:0]+8'd2], mem0[addr0[7:0]+8'd3]};
    if (rd1) rdata1 <= {mem1[addr1[7:0]], mem1[addr1[7:0]+8'd1], mem1[addr1[7:0]+8'd2], mem1[addr1[7:0]+8'd3]};
  end

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  wr_t q0[$];
  wr_t q1[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic sb0_en = 1'b1;
  int   done0_n = 0, done1_n = 0;
  logic done0_prev = 1'b0, done1_prev = 1'b0;
  int   exp_cc0, exp_mc0, exp_cc1, exp_mc1;

  always @(negedge clk) begin
    wr_t e;
    if (rd0 || wr0) begin
      chk("rd_wr_excl0", 32'(rd0 & wr0), 32'd0);
      chk("addr_align0", 32'(addr0[1:0]), 32'd0);
    end
    if (wr0 && sb0_en) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL wr0_extra: write to 0x%04h with nothing expected", addr0);
      end else begin
        e = q0.pop_front();
        chk("wr0_addr", 32'(addr0), 32'(e.addr));
        chk("wr0_data", wdata0, e.data);
      end
    end
    if (wr1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL wr1_extra: write to 0x%04h with nothing expected", addr1);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 32'(addr1), 32'(e.addr));
        chk("wr1_data", wdata1, e.data);
      end
    end
    if (done0_prev) begin
      chk("clock_count0", 32'(cc0), 32'(exp_cc0));
      chk("mac_count0", 32'(mc0), 32'(exp_mc0));
    end
    if (done1_prev) begin
      chk("clock_count1", 32'(cc1), 32'(exp_cc1));
      chk("mac_count1", 32'(mc1), 32'(exp_mc1));
    end
    done0_prev <= done0;
    done1_prev <= done1;
    if (done0) done0_n <= done0_n + 1;
    if (done1) done1_n <= done1_n + 1;
  end

  int A0 [2][4];
  int B0 [4][2];
  int A1 [3][1];
  int B1 [1][3];

  task automatic put0(input int w, input logic [31:0] v);
    mem0[4*w] = v[31:24]; mem0[4*w+1] = v[23:16]; mem0[4*w+2] = v[15:8]; mem0[4*w+3] = v[7:0];
  endtask

  task automatic put1(input int w, input logic [31:0] v);
    mem1[4*w] = v[31:24]; mem1[4*w+1] = v[23:16]; mem1[4*w+2] = v[15:8]; mem1[4*w+3] = v[7:0];
  endtask

  task automatic load0();
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) put0(i*4 + k, A0[i][k]);
    for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) put0(8 + k*2 + j, B0[k][j]);
  endtask

  task automatic clear0();
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) A0[i][k] = 0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) B0[k][j] = 0;
  endtask

  task automatic set_example0();
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) A0[i][k] = i*4 + k + 1;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) B0[k][j] = k*2 + j + 1;
  endtask

  // One full run on the default-size engine; p1/p2 are run-relative cycles to re-pulse start (0 = none).
  task automatic run0(input string tag, input int p1, input int p2);
    wr_t e;
    int  d0, cyc, c;
    load0();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = 0;
        for (int k = 0; k < 4; k++) c += A0[i][k] * B0[k][j];
        e.addr = 16'(64 + 4*(i*2 + j));
        e.data = c;
        q0.push_back(e);
      end
    exp_cc0 = 2*2*(3*4 + 1) + 1;
    exp_mc0 = 2*2*4;
    d0 = done0_n;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy0), 32'd1);
    cyc = 1;
    while (done0_n == d0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start0 = (cyc == p1 || cyc == p2);
    end
    start0 = 1'b0;
    if (done0_n == d0) begin
      n_chk++;
      $display("FAIL %s_timeout: no done after %0d cycles", tag, cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, 32'(done0_n - d0), 32'd1);
    chk({tag, "_writes_drained"}, 32'(q0.size()), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy0), 32'd0);
    q0.delete();
  endtask

  task automatic run1();
    wr_t e;
    int  d1, cyc;
    for (int i = 0; i < 3; i++) put1(i, A1[i][0]);
    for (int j = 0; j < 3; j++) put1(3 + j, B1[0][j]);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        e.addr = 16'(24 + 4*(i*3 + j));
        e.data = A1[i][0] * B1[0][j];
        q1.push_back(e);
      end
    exp_cc1 = 3*3*(3*1 + 1) + 1;
    exp_mc1 = 9;
    d1 = done1_n;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cyc = 1;
    while (done1_n == d1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done1_n == d1) begin
      n_chk++;
      $display("FAIL p1_timeout: no done after %0d cycles", cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("p1_done_pulses", 32'(done1_n - d1), 32'd1);
    chk("p1_writes_drained", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_rd_wr", 32'({rd0, wr0}), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_wdata", wdata0, 32'd0);
    chk("rst_counts", {cc0, mc0}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_example0();
    run0("example", 0, 0);

    clear0(); A0[0][0] = -3; B0[0][0] = 5;
    run0("signed", 0, 0);

    clear0(); A0[0][0] = 32'h4000_0000; B0[0][0] = 4; A0[0][1] = 1; B0[1][0] = 7;
    run0("overflow", 0, 0);

    set_example0();
    run0("restart_ignored", 10, 30);

    // Abort mid-run: everything must drop the instant reset asserts.
    sb0_en = 1'b0;
    load0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_rd_wr", 32'({rd0, wr0}), 32'd0);
    chk("abort_counts", {cc0, mc0}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    sb0_en = 1'b1;
    run0("after_abort", 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) A0[i][k] = $urandom;
      for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++)
        B0[k][j] = (r < 2) ? $urandom : int'($urandom_range(0, 200)) - 100;
      run0("random", 0, 0);
    end

    for (int i = 0; i < 3; i++) A1[i][0] = i + 1;
    for (int j = 0; j < 3; j++) B1[0][j] = j + 4;
    run1();

    for (int i = 0; i < 3; i++) A1[i][0] = $urandom;
    for (int j = 0; j < 3; j++) B1[0][j] = $urandom;
    run1();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
